// File: rtl/dvi_pkg.sv
// Shared constants for the DVI timing block: default 640x480@60 raster timing,
// RGB slice positions and the colour-bar table.
package dvi_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_CW       = 12;

  localparam int unsigned R_HI = 23;
  localparam int unsigned R_LO = 16;
  localparam int unsigned G_HI = 15;
  localparam int unsigned G_LO = 8;
  localparam int unsigned B_HI = 7;
  localparam int unsigned B_LO = 0;

  localparam int unsigned NUM_BARS = 8;

  // White, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/dvi_raster_counter.sv
// Horizontal/vertical raster counters with active-area, sync and frame-start
// decode, all combinational from the current count.
module dvi_raster_counter
  import dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_end,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_ON  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic frame_end;

  always_comb begin
    line_end    = (h_cnt == H_LAST);
    frame_end   = line_end && (v_cnt == V_LAST);
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs          = (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
    vs          = (v_cnt >= VS_ON) && (v_cnt < VS_OFF);
    frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= line_end ? '0 : h_cnt + 1'b1;
      if (frame_end) begin
        v_cnt <= '0;
      end else if (line_end) begin
        v_cnt <= v_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dvi_video_timing.sv
// DVI raster timing and two-stage output pipeline feeding three TMDS encoders.
// Optional colour-bar generator enabled by defining DVI_TEST_PATTERN_EN.
module dvi_video_timing
  import dvi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk_pixel,
  input  logic          rst,
  input  logic [23:0]   rgb_in,
`ifdef DVI_TEST_PATTERN_EN
  input  logic          pattern_sel,
`endif
  output logic [CW-1:0] cx,
  output logic [CW-1:0] cy,
  output logic          pix_req,
  output logic          frame_start,
  output logic [7:0]    ch0_data,
  output logic [7:0]    ch1_data,
  output logic [7:0]    ch2_data,
  output logic [1:0]    ch0_ctl,
  output logic [1:0]    ch1_ctl,
  output logic [1:0]    ch2_ctl,
  output logic          mode
);

  logic        line_end;
  logic        active, hs, vs;
  logic        active_d, hs_d, vs_d;
  logic [23:0] src_rgb;

  dvi_raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CW(CW)
  ) u_raster (
    .clk         (clk_pixel),
    .rst         (rst),
    .h_cnt       (cx),
    .v_cnt       (cy),
    .line_end    (line_end),
    .active      (active),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start)
  );

  assign pix_req = active;
  assign ch1_ctl = 2'b00;
  assign ch2_ctl = 2'b00;

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      active_d <= 1'b0;
      hs_d     <= 1'b0;
      vs_d     <= 1'b0;
    end else begin
      active_d <= active;
      hs_d     <= hs;
      vs_d     <= vs;
    end
  end

`ifdef DVI_TEST_PATTERN_EN
  localparam logic [CW-1:0] BAR_W_M1 = CW'((H_ACTIVE >> 3) - 1);

  // bar_pos/bar_idx track the current h_cnt; bar_idx_d aligns with active_d.
  logic [CW-1:0] bar_pos;
  logic [2:0]    bar_idx, bar_idx_d;
  logic          pat_d;

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      bar_pos   <= '0;
      bar_idx   <= '0;
      bar_idx_d <= '0;
      pat_d     <= 1'b0;
    end else begin
      bar_idx_d <= bar_idx;
      pat_d     <= pattern_sel;
      if (line_end) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BAR_W_M1) begin
        bar_pos <= '0;
        if (bar_idx != 3'(NUM_BARS - 1)) begin
          bar_idx <= bar_idx + 3'd1;
        end
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end
    end
  end

  assign src_rgb = pat_d ? bar_rgb(bar_idx_d) : rgb_in;
`else
  assign src_rgb = rgb_in;
`endif

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) begin
      mode     <= 1'b0;
      ch0_ctl  <= {~V_POL, ~H_POL};
      ch0_data <= 8'h00;
      ch1_data <= 8'h00;
      ch2_data <= 8'h00;
    end else begin
      mode     <= active_d;
      ch0_ctl  <= {vs_d ? V_POL : ~V_POL, hs_d ? H_POL : ~H_POL};
      ch0_data <= active_d ? src_rgb[B_HI:B_LO] : 8'h00;
      ch1_data <= active_d ? src_rgb[G_HI:G_LO] : 8'h00;
      ch2_data <= active_d ? src_rgb[R_HI:R_LO] : 8'h00;
    end
  end

endmodule

// File: tb/tb_dvi_video_timing.sv
// Scoreboard bench for dvi_video_timing on a scaled-down raster (80x12 totals).
module tb_dvi_video_timing;

  localparam int HA  = 64;
  localparam int HFP = 4;
  localparam int HSW = 8;
  localparam int HBP = 4;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 2;
  localparam int VT  = VA + VFP + VSW + VBP;
`ifdef DVI_TEST_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] rgb_in = 24'h0;
`ifdef DVI_TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif
  logic [11:0] cx, cy;
  logic        pix_req, frame_start, mode;
  logic [7:0]  ch0_data, ch1_data, ch2_data;
  logic [1:0]  ch0_ctl, ch1_ctl, ch2_ctl;

  dvi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0), .CW(12)
  ) dut (
    .clk_pixel   (clk_pixel),
    .rst         (rst),
    .rgb_in      (rgb_in),
`ifdef DVI_TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .cx          (cx),
    .cy          (cy),
    .pix_req     (pix_req),
    .frame_start (frame_start),
    .ch0_data    (ch0_data),
    .ch1_data    (ch1_data),
    .ch2_data    (ch2_data),
    .ch0_ctl     (ch0_ctl),
    .ch1_ctl     (ch1_ctl),
    .ch2_ctl     (ch2_ctl),
    .mode        (mode)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int due;
    int cx;
    int cy;
    bit pr;
    bit fs;
  } now_t;

  typedef struct {
    int          due;
    bit          mode;
    logic [1:0]  ctl;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } late_t;

  now_t  qn[$];
  late_t ql[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    mh = 0, mv = 0, frame = 0;
  bit    sel_cur = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (cycle %0d, model %0d,%0d)", name, act, exp, cyc, mh,
               mv);
    end
  endtask

  function automatic logic [23:0] src(input int h, input int v);
    if (v % 2 == 0) return 24'h112233;
    return {8'(h), 8'(v), 8'hC3};
  endfunction

  function automatic logic [23:0] bar(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic push_late(input int h, input int v, input bit sel, input logic [23:0] rgb,
                           input int due);
    late_t       e;
    bit          act, hs, vs;
    logic [23:0] px;
    act   = (h < HA) && (v < VA);
    hs    = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs    = (v >= VA + VFP) && (v < VA + VFP + VSW);
    px    = !act ? 24'h0 : (sel ? bar(h / (HA / 8)) : rgb);
    e.due = due;
    e.mode = act;
    e.ctl = {vs ? 1'b0 : 1'b1, hs ? 1'b0 : 1'b1};
    e.r = px[23:16];
    e.g = px[15:8];
    e.b = px[7:0];
    ql.push_back(e);
  endtask

  task automatic push_idle(input int due);
    late_t e;
    e.due = due;
    e.mode = 1'b0;
    e.ctl = 2'b11;
    e.r = 8'h00;
    e.g = 8'h00;
    e.b = 8'h00;
    ql.push_back(e);
  endtask

  task automatic push_now(input int due);
    now_t e;
    e.due = due;
    e.cx = mh;
    e.cy = mv;
    e.pr = (mh < HA) && (mv < VA);
    e.fs = (mh == 0) && (mv == 0);
    qn.push_back(e);
  endtask

  // One pixel clock: serve rgb for the coordinate just completed, advance the model.
  task automatic step();
    int          ph, pv;
    bit          psel;
    logic [23:0] prgb;
    @(posedge clk_pixel);
    #1;
    cyc++;
    ph = mh;
    pv = mv;
    psel = sel_cur;
    prgb = src(ph, pv);
    rgb_in = prgb;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) begin
        mv = 0;
        frame++;
      end
    end
    sel_cur = PAT_EN && (frame == 1);
`ifdef DVI_TEST_PATTERN_EN
    pattern_sel = sel_cur;
`endif
    push_late(ph, pv, psel, prgb, cyc + 1);
    push_now(cyc);
  endtask

  initial begin
    forever begin
      @(negedge clk_pixel);
      while (qn.size() > 0 && qn[0].due <= cyc) begin
        now_t e;
        e = qn.pop_front();
        check("cx", 32'(cx), e.cx);
        check("cy", 32'(cy), e.cy);
        check("pix_req", 32'(pix_req), 32'(e.pr));
        check("frame_start", 32'(frame_start), 32'(e.fs));
      end
      while (ql.size() > 0 && ql[0].due <= cyc) begin
        late_t e;
        e = ql.pop_front();
        check("mode", 32'(mode), 32'(e.mode));
        check("ch0_ctl", 32'(ch0_ctl), 32'(e.ctl));
        check("ch1_ctl", 32'(ch1_ctl), 32'h0);
        check("ch2_ctl", 32'(ch2_ctl), 32'h0);
        check("ch2_data", 32'(ch2_data), 32'(e.r));
        check("ch1_data", 32'(ch1_data), 32'(e.g));
        check("ch0_data", 32'(ch0_data), 32'(e.b));
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    repeat (3) @(posedge clk_pixel);
    #1;
    check("rst_cx", 32'(cx), 0);
    check("rst_cy", 32'(cy), 0);
    check("rst_pix_req", 32'(pix_req), 1);
    check("rst_frame_start", 32'(frame_start), 1);
    check("rst_mode", 32'(mode), 0);
    check("rst_ch0_ctl", 32'(ch0_ctl), 32'h3);
    check("rst_data", {8'h0, ch2_data, ch1_data, ch0_data}, 32'h0);

    rst = 1'b0;
    cyc = 0;
    push_now(cyc);
    push_idle(cyc);
    push_idle(cyc + 1);

    // Frame 0 plain source, frame 1 colour bars (when built in), then mid-frame reset.
    repeat (2 * HT * VT) step();
    guard = 0;
    while (!(mh == 30 && mv == 4) && guard < HT * VT) begin
      step();
      guard++;
    end
    check("reach_reset_point", 32'(guard < HT * VT), 1);

    qn.delete();
    ql.delete();
    #2 rst = 1'b1;
    #1;
    check("async_mode", 32'(mode), 0);
    check("async_ch0_ctl", 32'(ch0_ctl), 32'h3);
    check("async_data", {8'h0, ch2_data, ch1_data, ch0_data}, 32'h0);
    check("async_cx", 32'(cx), 0);
    check("async_cy", 32'(cy), 0);
    repeat (2) @(posedge clk_pixel);
    #1;
    rst = 1'b0;
    mh = 0;
    mv = 0;
    frame = 3;
    sel_cur = 1'b0;
`ifdef DVI_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    check("rel_frame_start", 32'(frame_start), 1);
    push_now(cyc);
    push_idle(cyc);
    push_idle(cyc + 1);
    repeat (HT * VT + 5) step();

    @(posedge clk_pixel);
    #1;
    cyc++;
    @(negedge clk_pixel);
    #1;
    check("queues_drained", qn.size() + ql.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvi_video_timing.md
Name: dvi_video_timing

Overview:
- Upstream stage for the three TMDS channel encoders.
- Generates horizontal/vertical raster counters and sync and active-video timing.
- Requests pixels from the video source, then drives each encoder's `video_data[7:0]`, `control_data[1:0]` and `mode`, registered and aligned on `clk_pixel`.
- Default timing is 640x480@60 (25.175 MHz pixel clock).

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync asserted level (0 = active low)
- `V_POL`, 0, vsync asserted level (0 = active low)
- `CW`, 12, counter width; must satisfy `2^CW > max(H_TOTAL, V_TOTAL)`

Ports:
- `clk_pixel`  in  1  pixel clock; the block's only clock
- `rst`  in  1  asynchronous, active-high reset
- `rgb_in`  in  24  {R,G,B} for the coordinate requested one cycle earlier
- `cx`  out  CW  current horizontal count (0..H_TOTAL-1)
- `cy`  out  CW  current vertical count (0..V_TOTAL-1)
- `pix_req`  out  1  high when (`cx`,`cy`) is in the active area
- `frame_start`  out  1  one-cycle pulse when `cx`==0 and `cy`==0
- `ch0_data`, `ch1_data`, `ch2_data`  out  8 each  B, G, R to encoders 0/1/2
- `ch0_ctl`  out  2  {vsync, hsync} to encoder 0
- `ch1_ctl`, `ch2_ctl`  out  2 each  CTL bits; always 2'b00 in DVI
- `mode`  out  1  1 = video, 0 = control; shared by all channels

Behaviour:
- Derived totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800); `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP` (525).
- Counters:
  - `h_cnt` increments every clock and wraps H_TOTAL-1 -> 0.
  - `v_cnt` increments only on the clock where `h_cnt` wraps, and wraps V_TOTAL-1 -> 0 on that same clock.
  - `cx` = `h_cnt`, `cy` = `v_cnt`, driven directly from the registers.
- Stage 0 (cycle n, combinational from the counters):
  - `active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE`; `pix_req = active`.
  - `hs = (h_cnt >= H_ACTIVE+H_FP) && (h_cnt < H_ACTIVE+H_FP+H_SYNC)`.
  - `vs` uses the same comparison on `v_cnt` with the V parameters, asserted for whole lines.
  - `frame_start = (h_cnt==0 && v_cnt==0)`.
- Stage 1 (end of cycle n): register `active`, `hs`, `vs`.
- Source contract: `rgb_in` for (`cx`,`cy`) of cycle n is valid throughout cycle n+1.
- Stage 2 (end of cycle n+1):
  - `mode` <= `active_d`.
  - `ch0_ctl` <= {`vs_d` ? V_POL : ~V_POL, `hs_d` ? H_POL : ~H_POL}.
  - `chX_data` <= `active_d` ? `rgb_in` slice : 8'h00.
- Latency: outputs describe coordinate n during cycle n+2. The encoder adds its own register stage after this.
- Outside the active area, `ch*_data` = 0; encoders ignore data when `mode`=0.
- Reset (async assert, sync release):
  - `h_cnt` = `v_cnt` = 0 and all pipeline registers cleared.
  - `mode` = 0, `ch*_data` = 0, `ch1_ctl` = `ch2_ctl` = 0.
  - `ch0_ctl` = {~V_POL, ~H_POL}, i.e. sync deasserted.
  - `pix_req` and `frame_start` are high immediately after reset, since (0,0) is active.
- Reset mid-frame restarts the raster at (0,0) with no partial line emitted.
- Boundaries:
  - `h_cnt`==H_ACTIVE-1 is the last active pixel.
  - hsync asserts at `h_cnt`==656 and deasserts at 752 (defaults).
  - vsync covers lines 490-491.

Optional Feature:
- Macro: `DVI_TEST_PATTERN_EN`.
- When defined:
  - Adds input `pattern_sel` (1 bit).
  - When `pattern_sel`=1, stage 2 replaces `rgb_in` with 8 vertical colour bars of width H_ACTIVE>>3, tracked by a bar counter that resets at `h_cnt`==0.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Components are 8'hFF or 8'h00.
  - `pattern_sel` is sampled with stage-1 timing.
- When undefined: the port is absent and `rgb_in` is always used.

Decomposition:
- Package `dvi_pkg`:
  - default 640x480 timing constants;
  - `CW`;
  - RGB slice indices;
  - colour-bar constant table.
- One natural sub-module, `dvi_raster_counter`: counters plus the `hs`/`vs`/`active`/`frame_start` decode. The top level holds the pipeline and the pattern mux.

Test Plan:
- Release reset, run 800*525 clocks -> `frame_start` pulses exactly once per 420000 clocks; `cx` wraps 799->0 and `cy` wraps 524->0 on the same edge.
- Line 0 -> `pix_req` high for `cx` 0..639, low for 640..799. `mode` high exactly 2 clocks later for 640 consecutive clocks.
- `rgb_in` = 24'h112233 held during active -> `ch2_data`=8'h11, `ch1_data`=8'h22, `ch0_data`=8'h33 while `mode`=1; all 8'h00 when `mode`=0.
- H_POL=V_POL=0 -> `ch0_ctl[0]`=0 for output slots of `cx` 656..751 (96 clocks); `ch0_ctl[1]`=0 for lines 490-491 only; `ch1_ctl`/`ch2_ctl` always 00.
- Assert `rst` at `cx`=300, `cy`=200 -> `mode`=0, `ch0_ctl`=2'b11 asynchronously; after release `cx`=`cy`=0 and `frame_start`=1.
- `DVI_TEST_PATTERN_EN` defined, `pattern_sel`=1 -> `cx` 0..79 emit FF/FF/FF, 80..159 FF/FF/00 (R/G/B), and 560..639 00/00/00.
